rng_harvester: RTL

RNG_HARVESTER -- requirements
Module: rng_harvester

---
 rtl/rng_harvester_pkg.sv | 17 +
 rtl/rng_harvester_if.sv | 23 ++
 rtl/rng_fifo.sv | 75 +++++++
 rtl/rng_harvester.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rng_harvester_pkg.sv
// Shared definitions for the RNG harvester slice.
//   state_t          : harvester FSM states
//   *_DEF            : default parameter values for WARMUP_CYCLES, DEPTH, RCT_LIMIT
package rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_COLLECT,
        ST_FAIL
    } state_t;

    localparam int unsigned WARMUP_CYCLES_DEF = 16;
    localparam int unsigned DEPTH_DEF         = 4;
    localparam int unsigned RCT_LIMIT_DEF     = 8;

endpackage

// File: rtl/rng_harvester_if.sv
// Read-side handshake between the harvester FIFO and a byte consumer.
//   rd_data  : FIFO head byte
//   rd_valid : FIFO non-empty
//   rd_ready : consumer accepts rd_data when rd_valid & rd_ready
interface rng_harvester_if;

    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (
        output rd_data,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );

endinterface

// File: rtl/rng_fifo.sv
// DEPTH x 8 output FIFO with registered head outputs and synchronous flush.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empty the FIFO at the next edge
//   push       : write push_data (ignored when full without a pop)
//   pop_req    : consumer ready; a pop happens only while rd_valid
//   rd_data    : registered head byte (0 when empty)
//   rd_valid   : registered non-empty flag
//   count      : current number of stored bytes
module rng_fifo
    import rng_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop_req,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rptr_n;
    logic [CW-1:0] count_n;
    logic [7:0]    head_n;
    logic          pop;
    logic          wr;

    always_comb begin
        pop = pop_req && rd_valid;
        wr  = push && ((count != CW'(DEPTH)) || pop);
        rptr_n = pop ? rptr + 1'b1 : rptr;
        case ({wr, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
        // When the write lands in the slot that becomes the head, the queue
        // was otherwise empty, so the head must bypass the memory.
        head_n = (wr && (rptr_n == wptr)) ? push_data : mem[rptr_n];
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            rptr     <= rptr_n;
            count    <= count_n;
            rd_valid <= (count_n != '0);
            rd_data  <= (count_n != '0) ? head_n : '0;
        end
    end

endmodule

// File: rtl/rng_harvester.sv
// Ring-oscillator entropy harvester: warmup, von Neumann debiasing, byte
// assembly, repetition-count health test and an output FIFO.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : level request to harvest bytes
//   rng_data     : raw oscillator byte, one sample per cycle in COLLECT
//   rng_en       : registered enable to the oscillator bank
//   health_fail  : sticky repetition-count failure
//   rd           : FIFO read handshake (master side)
module rng_harvester
    import rng_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = WARMUP_CYCLES_DEF,
    parameter int unsigned DEPTH         = DEPTH_DEF,
    parameter int unsigned RCT_LIMIT     = RCT_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        rng_data,
    output logic              rng_en,
    output logic              health_fail,
    rng_harvester_if.master   rd
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned RW = $clog2(RCT_LIMIT + 1);

    state_t        state;
    logic [WW-1:0] warm_cnt;
    logic          pair_half;
    logic          pair_p0;
    logic [7:0]    acc;
    logic [2:0]    bit_cnt;
    logic [RW-1:0] rct_cnt;
    logic [7:0]    rct_last;

    logic [CW-1:0] fifo_count;
    logic          pop;
    logic          full;
    logic          in_collect;
    logic          p_cur;
    logic [RW-1:0] rct_next;
    logic          trip;
    logic          accept;
    logic [7:0]    assembled;
    logic          push;
    logic          fills;

    always_comb begin
        pop        = rd.rd_valid && rd.rd_ready;
        full       = (fifo_count == CW'(DEPTH));
        in_collect = (state == ST_COLLECT) && enable;
        p_cur      = ^rng_data;
        // rct_cnt == 0 marks the first sample after entering COLLECT
        rct_next   = ((rct_cnt != '0) && (rng_data == rct_last)) ? rct_cnt + 1'b1 : RW'(1);
        trip       = in_collect && (rct_next >= RW'(RCT_LIMIT));
        accept     = in_collect && pair_half && (pair_p0 != p_cur);
        assembled  = acc | (8'(pair_p0) << bit_cnt);
        push       = accept && (bit_cnt == 3'd7) && !trip;
        fills      = push && !pop && (fifo_count == CW'(DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rng_en      <= 1'b0;
            health_fail <= 1'b0;
            warm_cnt    <= '0;
            pair_half   <= 1'b0;
            pair_p0     <= 1'b0;
            acc         <= '0;
            bit_cnt     <= '0;
            rct_cnt     <= '0;
            rct_last    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && !full && !health_fail) begin
                        state    <= ST_WARMUP;
                        rng_en   <= 1'b1;
                        warm_cnt <= '0;
                    end
                end
                ST_WARMUP: begin
                    if (!enable) begin
                        state  <= ST_IDLE;
                        rng_en <= 1'b0;
                    end else if (warm_cnt == WW'(WARMUP_CYCLES - 1)) begin
                        state     <= ST_COLLECT;
                        pair_half <= 1'b0;
                        acc       <= '0;
                        bit_cnt   <= '0;
                        rct_cnt   <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (!enable) begin
                        state     <= ST_IDLE;
                        rng_en    <= 1'b0;
                        pair_half <= 1'b0;
                        acc       <= '0;
                        bit_cnt   <= '0;
                    end else if (trip) begin
                        state       <= ST_FAIL;
                        rng_en      <= 1'b0;
                        health_fail <= 1'b1;
                        acc         <= '0;
                        bit_cnt     <= '0;
                        pair_half   <= 1'b0;
                    end else begin
                        rct_cnt   <= rct_next;
                        rct_last  <= rng_data;
                        pair_half <= !pair_half;
                        if (!pair_half) begin
                            pair_p0 <= p_cur;
                        end else if (accept) begin
                            if (bit_cnt == 3'd7) begin
                                acc     <= '0;
                                bit_cnt <= '0;
                            end else begin
                                acc     <= assembled;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (fills) begin
                            state  <= ST_IDLE;
                            rng_en <= 1'b0;
                        end
                    end
                end
                ST_FAIL: begin
                    rng_en <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    rng_en <= 1'b0;
                end
            endcase
        end
    end

    rng_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (trip),
        .push      (push),
        .push_data (assembled),
        .pop_req   (rd.rd_ready),
        .rd_data   (rd.rd_data),
        .rd_valid  (rd.rd_valid),
        .count     (fifo_count)
    );

endmodule
